// File: rtl/if_fetch_queue.sv
// IF->ID fetch queue: DEPTH-entry show-ahead FIFO of {pc, instruction}; write-to-head latency 1 cycle.
// Backpressure: full (registered) stalls IF; pushes while full are dropped and flag sticky overflow.
module if_fetch_queue #(
  parameter int ADDRESS_LEN = 32,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [ADDRESS_LEN-1:0] pc_in,
  input  logic [ADDRESS_LEN-1:0] instruction_in,
  input  logic                   pop,
  output logic                   full,
  output logic                   valid_out,
  output logic [ADDRESS_LEN-1:0] pc_out,
  output logic [ADDRESS_LEN-1:0] instruction_out,
  output logic [CNT_W-1:0]       count,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDRESS_LEN-1:0] r_pc_mem  [DEPTH];
  logic [ADDRESS_LEN-1:0] r_ins_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push_ok = push && !w_full;
  assign w_pop_ok  = pop && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (push && w_full) r_overflow <= 1'b1;
    end
  end

  // Storage has no reset; empty-gating on the outputs hides stale contents.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_push_ok) begin
      r_pc_mem[r_wr_ptr]  <= pc_in;
      r_ins_mem[r_wr_ptr] <= instruction_in;
    end
  end

  assign full            = w_full;
  assign valid_out       = !w_empty;
  assign count           = r_count;
  assign overflow        = r_overflow;
  assign pc_out          = w_empty ? '0 : r_pc_mem[r_rd_ptr];
  assign instruction_out = w_empty ? '0 : r_ins_mem[r_rd_ptr];

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised fetch queue between the Instruction Fetch and Instruction Decode stages. It replaces the single-entry PC/instruction pipeline register with a DEPTH-entry show-ahead FIFO of {pc, instruction} pairs. Fetch keeps running while decode is stalled, until the queue fills. Flush empties the queue in one cycle on a taken branch.

## Interface
Parameters:
- ADDRESS_LEN, 32, width of the pc and instruction fields.
- DEPTH, 4, number of entries; a power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of `count`.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (taken branch).
- push  in  1  IF presents a fetched pair.
- pc_in  in  ADDRESS_LEN  PC+4 of the fetched instruction.
- instruction_in  in  ADDRESS_LEN  fetched instruction word.
- pop  in  1  ID consumes the head entry (ID drives `!freeze`).
- full  out  1  count == DEPTH; IF freezes its PC while this is high.
- valid_out  out  1  head entry present (count != 0).
- pc_out  out  ADDRESS_LEN  head pc; 0 when empty.
- instruction_out  out  ADDRESS_LEN  head instruction; 0 when empty.
- count  out  CNT_W  occupied entries, 0..DEPTH.
- overflow  out  1  sticky; set when a push is rejected. Cleared only by rst.

## Operation
- Storage: a DEPTH-entry array, a write pointer and a read pointer, each log2(DEPTH) bits wide, plus `count`.
  - Pointers wrap modulo DEPTH with no special case.
- Priority, highest first: rst, then flush, then push/pop.
- rst: pointers, count and overflow are set to 0. Array contents are don't-care. All outputs read 0.
- flush with no rst:
  - Pointers and count are set to 0. overflow is held.
  - push and pop in the same cycle are ignored; the pair fetched in the flush cycle is discarded.
- Push acceptance: a push is accepted iff count < DEPTH, evaluated on the pre-edge count.
  - The accepted pair is written at the write pointer and the write pointer increments.
  - A push while full is rejected, the array is unchanged, and overflow is set.
  - There is no full-bypass: a push and a pop in the same cycle while full accepts only the pop.
- Pop acceptance: a pop is accepted iff count != 0. The read pointer increments.
  - A pop while empty is ignored and does not raise an error.
- Simultaneous accepted push and pop: count is unchanged and both pointers advance.
- Empty and push in the same cycle: the push is accepted, the pop is ignored, and count becomes 1.
- Head outputs are a show-ahead read of array[read pointer], gated to all-zero when count == 0.
  - All-zero is the flushed-register bubble that ID already decodes as a no-op.
- full and valid_out are decoded from the registered count only. There is no combinational path from push, pop or flush to any output.

## Timing
- Write-to-head latency is 1 cycle. A push accepted at edge N into an empty queue gives valid_out=1 and the pair on pc_out/instruction_out after edge N.
- A pop at edge N exposes the next entry after edge N. If the queue was at count=1, outputs go to 0 and valid_out to 0 after edge N.
- full rises the cycle after the DEPTH-th accepted push.
  - IF must sample full before pushing. A push issued in the same cycle full rises is the legal last fill.
- flush takes effect at the edge where it is sampled; outputs are 0 the following cycle.
  - A push in the cycle after flush is accepted normally.
- rst in the middle of traffic behaves as flush and additionally clears overflow. The next edge after rst deasserts accepts a push.
- Sustained push and pop every cycle at any 0 < count < DEPTH gives a throughput of 1 pair per cycle with constant count.

## Test plan
- Reset, then fill: rst for 2 cycles, then push pc 0x4, 0x8, 0xC, 0x10 with pop=0 (DEPTH=4). Required: count 1,2,3,4, full=1 after the 4th edge, head pc=0x4. A 5th push (pc 0x14) sets overflow=1, and count stays 4.
- Drain: with the queue full, pop for 4 cycles. Required: head pc 0x8, 0xC, 0x10, then 0 with valid_out=0. A 5th pop leaves count 0.
- Wrap-around: push and pop together for 10 cycles at count=2 with instruction_in=0xE0000000+i. Required: head instructions appear in order, count stays 2, and no data corruption after the pointers wrap twice.
- Flush priority: at count=3, assert flush+push+pop together. Required: next cycle count=0, valid_out=0, pc_out=instruction_out=0, overflow unchanged. A push on the next cycle gives count=1.
- Full with push and pop: at count=4, push 0x20 and pop together. Required: count=3, head advances, 0x20 is absent, overflow=1.
- Reset mid-stream: with overflow=1 and count=2, assert rst with push=1. Required: count=0, overflow=0, outputs 0. A push after rst deasserts is accepted.
